// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared FSM state type and frame-length helper for activation_feeder
package feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } feeder_state_t;

   function automatic int unsigned frame_len(input int unsigned map_size);
      return map_size * map_size;
   endfunction

endpackage

// File: rtl/feeder_bank.sv
// rtl/feeder_bank.sv - one activation bank: simple dual-port RAM with registered read
module feeder_bank #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 36,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/activation_feeder.sv
// rtl/activation_feeder.sv - ping-pong activation buffer streaming frames to the accelerator
// FEEDER_TIMEOUT_EN enables the DRAIN watchdog that drives err.
module activation_feeder
   import feeder_pkg::*;
#(
   parameter int unsigned MAP_SIZE = 6,
   parameter int unsigned DW       = 8,
   parameter int unsigned RST_CYC  = 3,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            global_rst_n,
   input  logic [DW-1:0]   s_data,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [9*DW-1:0] w_data,
   input  logic            w_load,
   input  logic            start,
   input  logic            acc_end_op,
   output logic            acc_rst,
   output logic            acc_ce,
   output logic [DW-1:0]   activation,
   output logic [9*DW-1:0] weight1,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int unsigned N  = frame_len(MAP_SIZE);
   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + RST_CYC + 2);
   localparam logic [AW-1:0] L_LAST     = AW'(N - 1);
   localparam logic [CW-1:0] L_RST_LAST = CW'(RST_CYC - 1);

   feeder_state_t   r_state, w_next;
   logic            r_fill_sel, r_fill_full;
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_addr;
   logic [CW-1:0]   r_cnt;
   logic [9*DW-1:0] r_weight;
   logic            w_wr, w_swap, w_rd_en, w_timeout;
   logic [DW-1:0]   w_rd0, w_rd1, w_stream_data;

   // s_ready is low whenever a swap is possible, so a write never coincides with one.
   assign s_ready = !r_fill_full;
   assign w_wr    = s_valid && s_ready;
   assign w_swap  = (r_state == ST_IDLE) && start && r_fill_full;

`ifdef FEEDER_TIMEOUT_EN
   localparam logic [CW-1:0] L_TMO = CW'(TIMEOUT);
   assign w_timeout = (r_state == ST_DRAIN) && !acc_end_op && (r_cnt == L_TMO);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) r_state <= ST_IDLE;
      else               r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      acc_rst   = !global_rst_n;
      acc_ce    = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      w_rd_en   = 1'b0;
      w_rd_addr = '0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_swap) w_next = ST_RST;
         end
         ST_RST: begin
            acc_rst = 1'b1;
            // Prefetch word 0 so it is on the output in the first STREAM cycle.
            if (r_cnt == L_RST_LAST) begin
               w_next  = ST_STREAM;
               w_rd_en = 1'b1;
            end
         end
         ST_STREAM: begin
            acc_ce = 1'b1;
            if (r_rd_ptr == L_LAST) begin
               w_next = ST_DRAIN;
            end else begin
               w_rd_en   = 1'b1;
               w_rd_addr = r_rd_ptr + 1'b1;
            end
         end
         ST_DRAIN: begin
            acc_ce = 1'b1;
            if (acc_end_op)     w_next = ST_DONE;
            else if (w_timeout) w_next = ST_IDLE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         r_fill_sel  <= 1'b0;
         r_fill_full <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_weight    <= '0;
      end else begin
         if (w_wr) begin
            if (r_wr_ptr == L_LAST) begin
               r_fill_full <= 1'b1;
               r_wr_ptr    <= '0;
            end else begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
         end
         if (w_swap) begin
            r_fill_sel  <= ~r_fill_sel;
            r_fill_full <= 1'b0;
            r_wr_ptr    <= '0;
         end
         if (r_state == ST_RST)        r_cnt <= (r_cnt == L_RST_LAST) ? '0 : r_cnt + 1'b1;
         else if (r_state == ST_DRAIN) r_cnt <= r_cnt + 1'b1;
         else                          r_cnt <= '0;
         if (r_state == ST_STREAM) r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
         else                      r_rd_ptr <= '0;
         if ((r_state == ST_IDLE) && w_load) r_weight <= w_data;
      end
   end

   feeder_bank #(.DW(DW), .DEPTH(N), .AW(AW)) u_bank0 (
      .clk       (clk),
      .i_wr_en   (w_wr && !r_fill_sel),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (s_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd0)
   );

   feeder_bank #(.DW(DW), .DEPTH(N), .AW(AW)) u_bank1 (
      .clk       (clk),
      .i_wr_en   (w_wr && r_fill_sel),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (s_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd1)
   );

   assign w_stream_data = r_fill_sel ? w_rd0 : w_rd1;
   assign activation    = (r_state == ST_STREAM) ? w_stream_data : '0;
   assign weight1       = r_weight;
   assign err           = w_timeout;

endmodule

// File: tb/tb_activation_feeder.sv
// tb/tb_activation_feeder.sv - randomized self-checking bench for activation_feeder
module tb_activation_feeder;

   localparam int N       = 36;
   localparam int R       = 3;
   localparam int TIMEOUT = 255;
   localparam logic [71:0] K_W = 72'hF9170FD1F68DFA93F4;

   logic        clk = 1'b0;
   logic        global_rst_n = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [71:0] w_data = '0;
   logic        w_load = 1'b0;
   logic        start = 1'b0;
   logic        acc_end_op = 1'b0;
   logic        acc_rst, acc_ce, busy, done, err;
   logic [7:0]  activation;
   logic [71:0] weight1;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;

   // Model: fill-bank contents, launched frame, and cycles elapsed since launch.
   logic [7:0]  m_fill[$];
   logic [7:0]  m_frame[$];
   bit          m_active = 0;
   bit          m_done   = 0;
   int          m_c      = 0;
   logic [71:0] m_weight = '0;

   activation_feeder dut (
      .clk(clk), .global_rst_n(global_rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .w_data(w_data), .w_load(w_load), .start(start), .acc_end_op(acc_end_op),
      .acc_rst(acc_rst), .acc_ce(acc_ce), .activation(activation), .weight1(weight1),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit timeout_hit();
`ifdef FEEDER_TIMEOUT_EN
      return m_active && !m_done && (m_c >= R + N) && (m_c - (R + N) == TIMEOUT) && !acc_end_op;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge global_rst_n);
         if (!global_rst_n) begin
            m_fill.delete();
            m_frame.delete();
            m_active = 0; m_done = 0; m_c = 0; m_weight = '0;
         end else begin
            bit wr_ok, launch, tmo;
            wr_ok  = s_valid && (m_fill.size() < N);
            launch = !m_active && start && (m_fill.size() == N);
            tmo    = timeout_hit();
            if (w_load && !m_active) m_weight = w_data;
            if (launch) begin
               m_frame = m_fill;
               m_fill.delete();
               m_active = 1; m_done = 0; m_c = 0;
            end else if (m_active) begin
               if (m_done)              m_active = 0;
               else if (m_c < R + N)    m_c++;
               else if (acc_end_op)     m_done = 1;
               else if (tmo)            m_active = 0;
               else                     m_c++;
            end
            if (wr_ok) m_fill.push_back(s_data);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         begin
            bit in_rst, in_str, in_drn;
            in_rst = m_active && !m_done && (m_c < R);
            in_str = m_active && !m_done && (m_c >= R) && (m_c < R + N);
            in_drn = m_active && !m_done && (m_c >= R + N);
            chk("s_ready", s_ready, m_fill.size() < N);
            chk("busy", busy, m_active);
            chk("done", done, m_active && m_done);
            chk("acc_rst", acc_rst, in_rst || !global_rst_n);
            chk("acc_ce", acc_ce, in_str || in_drn);
            chk("activation", activation, in_str ? m_frame[m_c - R] : 8'h00);
            chk("weight1", weight1, m_weight);
            chk("err", err, timeout_hit());
            if (done) n_done++;
         end
      end
   end

   task automatic fill(input logic [7:0] base, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         s_data = base + 8'(i);
         s_valid = 1'b1;
         step();
      end
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_ce(input string tag, output int rst_cnt);
      int b = 0;
      rst_cnt = 0;
      while (!acc_ce && b < 50) begin
         if (acc_rst) rst_cnt++;
         step();
         b++;
      end
      chk(tag, acc_ce, 1'b1);
   endtask

   task automatic finish_frame(input string tag);
      int b = 0;
      while (!(acc_ce && !busy ? 1'b0 : (acc_ce && activation == 8'h00 && b >= N)) && b < 200) begin
         step();
         b++;
      end
      acc_end_op = 1'b1;
      step();
      acc_end_op = 1'b0;
      chk(tag, done, 1'b1);
      step();
   endtask

   initial begin
      int rc, b;
      logic [95:0] rnd;
      step(); step(); step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_acc_rst", acc_rst, 1'b1);
      chk("rst_weight", weight1, 72'h0);
      chk("rst_act", activation, 8'h00);
      chk("rst_ce", acc_ce, 1'b0);
      global_rst_n = 1'b1;
      step();

      // Frame A 0x00..0x23, weight load, then stream A while filling B.
      fill(8'h00, N);
      chk("ready_full", s_ready, 1'b0);
      w_data = K_W; w_load = 1'b1;
      step();
      w_load = 1'b0;
      chk("w_load_idle", weight1, K_W);
      pulse_start();
      wait_ce("ce_a", rc);
      chk("rst_cycles", rc, 3);
      b = 0;
      for (int i = 0; i < N; i++) begin
         bit acc;
         chk("act_a", activation, 8'(i));
         chk("ce_a_run", acc_ce, 1'b1);
         if (i == 6) begin
            w_load = 1'b0;
            chk("w_hold", weight1, K_W);
         end
         if (i == 5) begin
            w_data = 72'h123456789ABCDEF012; w_load = 1'b1;
         end
         s_valid = (b < N); s_data = 8'h40 + 8'(b);
         acc = s_valid && s_ready;
         step();
         if (acc) b++;
      end
      s_valid = 1'b0;
      chk("b_full", s_ready, 1'b0);
      for (int i = 0; i < 9; i++) step();
      acc_end_op = 1'b1;
      step();
      acc_end_op = 1'b0;
      chk("done_a", done, 1'b1);
      step();
      chk("done_a_once", done, 1'b0);
      chk("idle_a", busy, 1'b0);
      chk("done_count_a", n_done, 1);

      pulse_start();
      wait_ce("ce_b", rc);
      for (int i = 0; i < N; i++) begin
         chk("act_b", activation, 8'h40 + 8'(i));
         step();
      end
      acc_end_op = 1'b1;
      step();
      acc_end_op = 1'b0;
      chk("done_b", done, 1'b1);
      step();

      // 35 bytes only: start must be ignored.
      fill(8'h80, N - 1);
      pulse_start();
      chk("short_busy", busy, 1'b0);
      step();
      chk("short_rst", acc_rst, 1'b0);

      // Reset in STREAM cycle 20.
      fill(8'hA3, 1);
      pulse_start();
      wait_ce("ce_d", rc);
      for (int i = 0; i < 20; i++) step();
      global_rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 1'b0);
      chk("mid_ce", acc_ce, 1'b0);
      chk("mid_act", activation, 8'h00);
      chk("mid_acc_rst", acc_rst, 1'b1);
      chk("mid_weight", weight1, 72'h0);
      chk("mid_ready", s_ready, 1'b1);
      step();
      global_rst_n = 1'b1;
      step();
      pulse_start();
      chk("start_after_rst", busy, 1'b0);
      fill(8'h10, N);
      pulse_start();
      chk("start_refilled", busy, 1'b1);
      wait_ce("ce_e", rc);
      for (int i = 0; i < N + 2; i++) step();
      acc_end_op = 1'b1;
      step();
      acc_end_op = 1'b0;
      step();

`ifdef FEEDER_TIMEOUT_EN
      begin
         int k, d0;
         fill(8'h20, N);
         pulse_start();
         wait_ce("ce_t", rc);
         for (int i = 0; i < N; i++) step();
         d0 = n_done;
         k = 0;
         while (!err && k < 600) begin
            step();
            k++;
         end
         chk("tmo_cycles", k, TIMEOUT);
         step();
         chk("tmo_busy", busy, 1'b0);
         chk("tmo_no_done", n_done, d0);
      end
`endif

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rnd = {$urandom, $urandom, $urandom};
         global_rst_n = ($urandom_range(0, 499) != 0);
         s_valid    = 1'($urandom_range(0, 1));
         s_data     = 8'($urandom);
         start      = ($urandom_range(0, 15) == 0);
         acc_end_op = ($urandom_range(0, 7) == 0);
         w_load     = ($urandom_range(0, 31) == 0);
         w_data     = rnd[71:0];
         step();
      end
      global_rst_n = 1'b1;
      s_valid = 1'b0; start = 1'b0; acc_end_op = 1'b0; w_load = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/activation_feeder.md
ACTIVATION_FEEDER -- requirements
Module: activation_feeder

Interface
REQ-001 Parameter MAP_SIZE, default 6: input feature-map side; one frame is MAP_SIZE*MAP_SIZE activations.
REQ-002 Parameter DW, default 8: activation/weight word width (Q4.4 fixed point).
REQ-003 Parameter RST_CYC, default 3: number of cycles the accelerator reset is held before each frame.
REQ-004 Parameter TIMEOUT, default 255: drain watchdog limit in cycles (used only with FEEDER_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 global_rst_n  in  1  asynchronous, active-low reset.
REQ-007 s_data  in  DW  upstream activation byte.
REQ-008 s_valid  in  1  s_data is valid.
REQ-009 s_ready  out  1  the feeder accepts s_data this cycle.
REQ-010 w_data  in  9*DW  3x3 kernel, with row-major MSB-first packing.
REQ-011 w_load  in  1  capture w_data into the weight register.
REQ-012 start  in  1  single-cycle pulse that launches streaming of the filled bank.
REQ-013 acc_end_op  in  1  end_op from the downstream accelerator.
REQ-014 acc_rst  out  1  active-high global_rst to the accelerator.
REQ-015 acc_ce  out  1  ce to the accelerator.
REQ-016 activation  out  DW  activation to the accelerator.
REQ-017 weight1  out  9*DW  held kernel to the accelerator.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.
REQ-019 done  out  1  one-cycle pulse when a frame completes.
REQ-020 err  out  1  one-cycle pulse on watchdog expiry (tied 0 without FEEDER_TIMEOUT_EN).

Function
REQ-021 Two banks, each MAP_SIZE^2 x DW, form a ping-pong buffer: the fill bank and the stream bank.
REQ-022 A write occurs on s_valid&s_ready and goes to the fill bank at address wr_ptr; wr_ptr then increments.
REQ-023 When wr_ptr reaches MAP_SIZE^2-1 and a write occurs, the fill bank is marked full and wr_ptr wraps to 0.
REQ-024 s_ready = !full(fill bank).
REQ-025 FSM states: IDLE, RST, STREAM, DRAIN, DONE.
REQ-026 IDLE -> RST on start, only when the fill bank is full; otherwise start is ignored.
REQ-027 On the same edge as IDLE -> RST, the banks swap: the stream bank becomes the former fill bank, and the new fill bank is cleared to empty.
REQ-028 RST: acc_rst=1 and acc_ce=0 for exactly RST_CYC cycles; then -> STREAM.
REQ-029 STREAM: acc_ce=1, and activation = stream_bank[rd_ptr] registered, with rd_ptr running 0..MAP_SIZE^2-1, one word per cycle and no gaps.
REQ-030 The first activation appears in the first STREAM cycle.
REQ-031 After the last word, the FSM goes to DRAIN.
REQ-032 DRAIN: acc_ce=1 and activation=0 until acc_end_op=1; then -> DONE.
REQ-033 acc_end_op is ignored outside DRAIN.
REQ-034 DONE: done=1 for one cycle, the stream bank is released, and the FSM goes to IDLE.
REQ-035 Filling of the other bank continues in every state, so upstream can prepare frame n+1 while frame n streams.
REQ-036 w_load updates weight1 on the next edge, but only in IDLE; in any other state it is ignored, so the kernel is stable for the whole frame.
REQ-037 If start arrives while busy, it is ignored.
REQ-038 If s_valid&s_ready coincides with the bank swap, the write lands in the new (empty) fill bank at address 0.

Reset
REQ-039 On global_rst_n=0, the FSM is forced to IDLE, both banks are marked empty, and wr_ptr=rd_ptr=0.
REQ-040 Reset values: weight1=0, activation=0, acc_ce=0, done=0, err=0, busy=0.
REQ-041 acc_rst=1 while global_rst_n=0, so the accelerator is held in reset too.
REQ-042 A reset mid-frame discards both banks; no done pulse is produced.

Configuration
REQ-043 With FEEDER_TIMEOUT_EN defined, a counter runs in DRAIN; if it reaches TIMEOUT without acc_end_op, err pulses for one cycle and the FSM goes to IDLE without a done pulse.
REQ-044 Without FEEDER_TIMEOUT_EN, DRAIN waits indefinitely and err is constant 0.

Structure
REQ-045 Shared package feeder_pkg holds the FSM state enum and a function returning the frame length MAP_SIZE*MAP_SIZE.
REQ-046 Sub-module feeder_bank implements one bank (simple dual-port, registered read), instantiated twice.

Verification
REQ-047 Reset, then stream 36 bytes 0x00..0x23 with s_valid held, then start -> s_ready drops after the 36th byte; acc_rst high for 3 cycles; then activation=0x00..0x23 on 36 consecutive acc_ce cycles.
REQ-048 Load w_data=0xF9170FD1F68DFA93F4 in IDLE -> weight1 equals that value; a w_load during STREAM -> weight1 unchanged.
REQ-049 During streaming of frame A, fill frame B (0x40..0x63); assert acc_end_op 10 cycles into DRAIN; then start -> done pulses once, and frame B streams in order after RST.
REQ-050 Start with the fill bank holding only 35 bytes -> FSM stays IDLE and busy=0.
REQ-051 Drop global_rst_n in cycle 20 of STREAM -> all outputs return to reset values at once, acc_rst=1, and a following start is ignored until 36 new bytes are written.
REQ-052 With FEEDER_TIMEOUT_EN and acc_end_op never asserted -> err pulses after 255 DRAIN cycles, busy drops, and done stays 0.
